// File: rtl/wb_uart_master_pkg.sv
// rtl/wb_uart_master_pkg.sv - command/response codes and state encodings for the UART debug master
package wb_uart_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_core.sv
// rtl/uart_byte_core.sv - 8N1 byte receiver/transmitter with input synchronizer
module uart_byte_core
  import wb_uart_master_pkg::*;
#(
  parameter int clks_per_bit = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);

  localparam int CW = $clog2(clks_per_bit + 1);
  localparam logic [CW-1:0] FULL = CW'(clks_per_bit - 1);
  localparam logic [CW-1:0] HALF = CW'(clks_per_bit / 2 - 1);

  logic          rxd_meta, rxd_sync, rxd_prev;
  rx_state_t     rx_state, rx_state_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  logic [9:0]    tx_frame;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rxd_prev && !rxd_sync) rx_state_next = RX_START;
      RX_START: if (rx_cnt == HALF) rx_state_next = rxd_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == FULL && rx_bit == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_cnt == FULL) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_state <= rx_state_next;
      rx_valid <= 1'b0;
      // counter restarts on every state change so each phase times from its own origin
      if (rx_state == RX_IDLE || rx_state_next != rx_state || rx_cnt == FULL)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state != RX_DATA)
        rx_bit <= '0;
      else if (rx_cnt == FULL) begin
        rx_bit   <= rx_bit + 1'b1;
        rx_shift <= {rxd_sync, rx_shift[7:1]};
      end
      if (rx_state == RX_STOP && rx_cnt == FULL && rxd_sync) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_frame <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        tx_frame <= {1'b1, tx_data, 1'b0};
        uart_txd <= 1'b0;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end
    end else if (tx_cnt == FULL) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_bit   <= tx_bit + 1'b1;
        uart_txd <= tx_frame[1];
        tx_frame <= {1'b1, tx_frame[9:1]};
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_uart_master.sv
// rtl/wb_uart_master.sv - UART command parser driving single classic Wishbone cycles
module wb_uart_master
  import wb_uart_master_pkg::*;
#(
  parameter int clk_freq     = 100000000,
  parameter int baud         = 115200,
  parameter int bus_timeout  = 255,
  parameter int byte_timeout = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy
);

  localparam int CPB = clk_freq / baud;
  localparam int BTW = $clog2(byte_timeout + 1);
  localparam int BUW = $clog2(bus_timeout + 1);
  localparam logic [BTW-1:0] BYTE_TO  = BTW'(byte_timeout);
  localparam logic [BUW-1:0] BUS_LAST = BUW'(bus_timeout - 1);

  parser_state_t  state, state_next;
  logic           rx_valid, tx_start, tx_busy;
  logic [7:0]     rx_data, tx_data;
  logic           is_wr;
  logic [1:0]     byte_cnt;
  logic [31:0]    adr_sh, dat_sh, rsp_data;
  logic [2:0]     rsp_cnt;
  logic [BTW-1:0] idle_cnt;
  logic [BUW-1:0] bus_cnt;
  logic           bus_done, bus_ok;

  uart_byte_core #(.clks_per_bit(CPB)) u_core (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  assign bus_done = wb_ack_i | wb_err_i | wb_rty_i;
  assign bus_ok   = wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign tx_data  = rsp_data[31:24];
  assign wb_cyc_o = (state == ST_BUS);
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = wb_cyc_o & is_wr;
  assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    case (state)
      ST_IDLE:
        if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) state_next = ST_ADDR;
      ST_ADDR:
        if (rx_valid && byte_cnt == 2'd3) state_next = is_wr ? ST_DATA : ST_BUS;
        else if (!rx_valid && idle_cnt == BYTE_TO) state_next = ST_IDLE;
      ST_DATA:
        if (rx_valid && byte_cnt == 2'd3) state_next = ST_BUS;
        else if (!rx_valid && idle_cnt == BYTE_TO) state_next = ST_IDLE;
      ST_BUS:
        if (bus_done || bus_cnt == BUS_LAST) state_next = ST_RESP;
      ST_RESP:
        if (!tx_busy) begin
          if (rsp_cnt != 3'd0) tx_start = 1'b1;
          else state_next = ST_IDLE;
        end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      is_wr    <= 1'b0;
      byte_cnt <= '0;
      adr_sh   <= '0;
      dat_sh   <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      rsp_data <= '0;
      rsp_cnt  <= '0;
      idle_cnt <= '0;
      bus_cnt  <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= (rx_valid || state == ST_IDLE) ? '0 : idle_cnt + 1'b1;
      bus_cnt  <= (state == ST_BUS) ? bus_cnt + 1'b1 : '0;
      if (state == ST_IDLE && state_next == ST_ADDR) begin
        is_wr    <= (rx_data == CMD_WR);
        byte_cnt <= '0;
      end
      if (rx_valid && (state == ST_ADDR || state == ST_DATA)) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (state == ST_ADDR) adr_sh <= {adr_sh[23:0], rx_data};
        else                  dat_sh <= {dat_sh[23:0], rx_data};
      end
      // the final byte bypasses the shifters so the bus sees it on the very next edge
      if (state_next == ST_BUS && state != ST_BUS) begin
        wb_adr_o <= (state == ST_ADDR) ? {adr_sh[23:0], rx_data} : adr_sh;
        wb_dat_o <= (state == ST_DATA) ? {dat_sh[23:0], rx_data} : 32'h0;
      end
      if (state == ST_BUS && state_next == ST_RESP) begin
        if (bus_ok && !is_wr) begin
          rsp_data <= wb_dat_i;
          rsp_cnt  <= 3'd4;
        end else begin
          rsp_data <= {(bus_ok ? RSP_ACK : RSP_NAK), 24'h0};
          rsp_cnt  <= 3'd1;
        end
      end
      if (tx_start) begin
        rsp_data <= {rsp_data[23:0], 8'h00};
        rsp_cnt  <= rsp_cnt - 1'b1;
      end
    end
  end

endmodule
